// File: rtl/apb3_reg_slave.sv
// APB3 completer: NUM_REGS RW control registers, read-only STATUS (0x20) and WCOUNT (0x24).
// Latency: completes after WAIT_STATES access cycles; pready/pslverr/prdata are combinational in ACCESS.
// Backpressure: pready held low for WAIT_STATES cycles; psel drop mid-transfer aborts and flags prot_err.
module apb3_reg_slave #(
    parameter int ADDR_W      = 8,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_W-1:0]       paddr,
    input  logic [31:0]             pwdata,
    output logic [31:0]             prdata,
    output logic                    pready,
    output logic                    pslverr,
    input  logic [31:0]             status_in,
    output logic [32*NUM_REGS-1:0]  ctrl_out,
    output logic                    prot_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_STATES);
    localparam logic [31:0] STATUS_OFF = 32'h20;
    localparam logic [31:0] WCOUNT_OFF = 32'h24;
    localparam logic [31:0] RW_LIMIT   = 32'(4 * NUM_REGS);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];
    logic [31:0] wcount_q, wcount_d;
    logic        prot_err_q, prot_err_d;

    logic [31:0] addr_ext;
    logic        aligned;
    logic        is_rw;
    logic        is_status;
    logic        is_wcount;
    logic        bad_access;
    logic        pready_w;
    logic        commit;
    logic [31:0] rd_data;

    // Address decode; widened so the comparisons are independent of ADDR_W.
    always_comb begin
        addr_ext   = 32'(paddr);
        aligned    = (paddr[1:0] == 2'b00);
        is_rw      = aligned && (addr_ext < RW_LIMIT);
        is_status  = (addr_ext == STATUS_OFF);
        is_wcount  = (addr_ext == WCOUNT_OFF);
        bad_access = !aligned
                   || !(is_rw || is_status || is_wcount)
                   || (pwrite && (is_status || is_wcount));
    end

    always_comb begin
        rd_data = 32'h0;
        if (is_status) begin
            rd_data = status_in;
        end else if (is_wcount) begin
            rd_data = wcount_q;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_ext == 32'(4 * i)) begin
                    rd_data = regs_q[i];
                end
            end
        end
    end

    always_comb begin
        pready_w = (state_q == ACCESS) && psel && penable && (wait_cnt_q == WAIT_LAST);
        commit   = pready_w && pwrite && !bad_access;
        pready   = pready_w;
        pslverr  = pready_w && bad_access;
        prdata   = (pready_w && !pwrite && !bad_access) ? rd_data : 32'h0;
        prot_err = prot_err_q;
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        prot_err_d = prot_err_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = 4'd0;
                if (psel && !penable) begin
                    state_d = ACCESS;
                end else if (psel && penable) begin
                    prot_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                    prot_err_d = 1'b1;
                end else if (pready_w) begin
                    state_d    = IDLE;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        wcount_d = wcount_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && (addr_ext == 32'(4 * i))) begin
                regs_d[i] = pwdata;
            end
        end
        if (commit) begin
            wcount_d = wcount_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            wcount_q   <= 32'h0;
            prot_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wcount_q   <= wcount_d;
            prot_err_q <= prot_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_ctrl
        assign ctrl_out[32*g +: 32] = regs_q[g];
    end

endmodule
